// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline enable/flush sequencing for load-use, redirect, mul/div and memory wait
module hazard_ctrl #(
    parameter int MULDIV_LAT  = 4,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4:0]             id_rs1,
    input  logic [4:0]             id_rs2,
    input  logic                   id_use_rs1,
    input  logic                   id_use_rs2,
    input  logic                   ex_memread,
    input  logic [4:0]             ex_rd,
    input  logic                   ex_branch_taken,
    input  logic                   ex_muldiv,
    input  logic                   mem_busy,
    output logic                   pc_en,
    output logic                   if_id_en,
    output logic                   id_ex_en,
    output logic                   ex_mem_en,
    output logic                   mem_wb_en,
    output logic                   if_id_flush,
    output logic                   id_ex_flush,
    output logic                   ex_mem_flush,
    output logic                   muldiv_done,
    output logic [STALL_CNT_W-1:0] stall_cycles
);
    typedef enum logic {RUN, MD_BUSY} state_t;
    localparam logic [3:0] LOAD = 4'(MULDIV_LAT - 2);
    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic       md_stall, load_use;
    assign md_stall = (state == RUN && ex_muldiv) || (state == MD_BUSY && cnt != 4'd0);
    assign load_use = ex_memread && ex_rd != 5'd0 &&
                      ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    // state and mul/div countdown register; reset abandons any op in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end
    // next state: everything holds while memory is busy
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (!mem_busy) begin
            if (state == RUN && ex_muldiv) begin
                state_n = MD_BUSY;
                cnt_n   = LOAD;
            end else if (state == MD_BUSY) begin
                state_n = cnt != 4'd0 ? MD_BUSY : RUN;
                cnt_n   = cnt != 4'd0 ? cnt - 4'd1 : cnt;
            end
        end
    end
    // enables and flushes by condition priority
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        muldiv_done  = !reset && !mem_busy && state == MD_BUSY && cnt == 4'd0;
        if (reset || mem_busy) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if (md_stall) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_flush = 1'b1;
        end else if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end
    // saturating count of frontend stall cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cycles <= '0;
        else if (!pc_en && stall_cycles != '1)
            stall_cycles <= stall_cycles + 1'b1;
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vector table plus multi-cycle sequences for hazard_ctrl
module tb_hazard_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic       id_use_rs1 = 0, id_use_rs2 = 0, ex_memread = 0, ex_branch_taken = 0;
    logic       ex_muldiv = 0, m2 = 0, mem_busy = 0;
    logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic       if_id_flush, id_ex_flush, ex_mem_flush, muldiv_done;
    logic [15:0] sc;
    logic       p2, ie2, de2, xe2, we2, if2, df2, xf2, dn2;
    logic [1:0] sc2;
    logic [8:0] o1, o2;
    int         n_cmp = 0, n_bad = 0;
    int         exp_sc = 0;

    localparam logic [8:0] NORM = 9'b111110000;
    localparam logic [8:0] MDS  = 9'b000110010;
    localparam logic [8:0] DONE = 9'b111110001;
    localparam logic [8:0] FRZ  = 9'b000000000;
    localparam logic [8:0] LU   = 9'b001110100;
    localparam logic [8:0] RDR  = 9'b111111100;
    localparam logic [8:0] RDD  = 9'b111111101;

    always #5 clk = ~clk;

    hazard_ctrl #(.MULDIV_LAT(4), .STALL_CNT_W(16)) dut (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_memread(ex_memread),
        .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .ex_muldiv(ex_muldiv),
        .mem_busy(mem_busy), .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
        .muldiv_done(muldiv_done), .stall_cycles(sc)
    );

    hazard_ctrl #(.MULDIV_LAT(2), .STALL_CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_memread(ex_memread),
        .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .ex_muldiv(m2),
        .mem_busy(mem_busy), .pc_en(p2), .if_id_en(ie2), .id_ex_en(de2),
        .ex_mem_en(xe2), .mem_wb_en(we2), .if_id_flush(if2),
        .id_ex_flush(df2), .ex_mem_flush(xf2),
        .muldiv_done(dn2), .stall_cycles(sc2)
    );

    assign o1 = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, ex_mem_flush, muldiv_done};
    assign o2 = {p2, ie2, de2, xe2, we2, if2, df2, xf2, dn2};

    typedef struct {
        logic [4:0] rs1, rs2;
        logic       u1, u2, mr;
        logic [4:0] rd;
        logic       br, bz;
        logic [8:0] exp;
    } vec_t;
    vec_t tv[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic clr();
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_memread = 0; ex_rd = 0; ex_branch_taken = 0; ex_muldiv = 0; m2 = 0; mem_busy = 0;
    endtask

    task automatic lu5();
        id_rs2 = 5; id_use_rs2 = 1; ex_memread = 1; ex_rd = 5;
    endtask

    task automatic step(input string name, input logic [8:0] req);
        @(negedge clk);
        #1 chk(name, 32'(o1), 32'(req));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1;
        #1 chk("rst_out", 32'(o1), 32'(FRZ));
        chk("rst_sc", 32'(sc), 0);
        chk("rst_out2", 32'(o2), 32'(FRZ));
        @(negedge clk);
        reset = 0;
    endtask

    initial begin
        tv.push_back('{0, 0, 0, 0, 0, 0, 0, 0, NORM});
        tv.push_back('{3, 5, 0, 1, 1, 5, 0, 0, LU});
        tv.push_back('{0, 4, 1, 0, 1, 0, 0, 0, NORM});
        tv.push_back('{7, 2, 0, 0, 1, 7, 0, 0, NORM});
        tv.push_back('{5, 5, 1, 1, 1, 5, 1, 0, RDR});
        tv.push_back('{12, 1, 1, 1, 1, 12, 0, 0, LU});
        tv.push_back('{12, 1, 1, 1, 0, 12, 0, 0, NORM});
        tv.push_back('{9, 6, 1, 0, 1, 6, 0, 0, NORM});
        tv.push_back('{31, 0, 1, 0, 1, 31, 0, 0, LU});
        tv.push_back('{1, 2, 1, 1, 1, 1, 1, 1, FRZ});
        tv.push_back('{4, 4, 1, 1, 1, 4, 0, 1, FRZ});
        tv.push_back('{0, 0, 0, 0, 0, 0, 1, 0, RDR});

        #1 chk("rst_hold", 32'(o1), 32'(FRZ));
        @(negedge clk);
        #1 chk("rst_hold_sc", 32'(sc), 0);
        @(negedge clk);
        reset = 0;
        for (int i = 0; i < tv.size(); i++) begin
            id_rs1 = tv[i].rs1; id_rs2 = tv[i].rs2; id_use_rs1 = tv[i].u1; id_use_rs2 = tv[i].u2;
            ex_memread = tv[i].mr; ex_rd = tv[i].rd; ex_branch_taken = tv[i].br; mem_busy = tv[i].bz;
            #1;
            chk($sformatf("vec%0d", i), 32'(o1), 32'(tv[i].exp));
            chk($sformatf("vec%0d_lat2", i), 32'(o2), 32'(tv[i].exp));
            chk($sformatf("vec%0d_sc", i), 32'(sc), 32'(exp_sc));
            chk($sformatf("vec%0d_sc_sat", i), 32'(sc2), 32'(exp_sc > 3 ? 3 : exp_sc));
            if (!tv[i].exp[8]) exp_sc++;
            @(negedge clk);
        end
        clr();
        #1 chk("tab_sc", 32'(sc), 32'(exp_sc));
        chk("tab_sc_sat", 32'(sc2), 3);

        do_reset();
        clr(); lu5();
        #1 chk("lu_bubble", 32'(o1), 32'(LU));
        @(negedge clk);
        clr();
        #1 chk("lu_after", 32'(o1), 32'(NORM));
        chk("lu_sc", 32'(sc), 1);

        @(negedge clk);
        lu5(); ex_branch_taken = 1;
        #1 chk("redir", 32'(o1), 32'(RDR));
        @(negedge clk);
        clr();
        #1 chk("redir_after", 32'(o1), 32'(NORM));
        chk("redir_sc", 32'(sc), 1);

        ex_muldiv = 1;
        #1 chk("md0", 32'(o1), 32'(MDS));
        step("md1", MDS);
        step("md2", MDS);
        step("md_done", DONE);
        @(negedge clk);
        ex_muldiv = 0;
        #1 chk("md_run", 32'(o1), 32'(NORM));
        chk("md_sc", 32'(sc), 4);

        ex_muldiv = 1;
        #1 chk("mb0", 32'(o1), 32'(MDS));
        mem_busy = 1;
        step("mb1_frz", FRZ);
        step("mb2_frz", FRZ);
        mem_busy = 0;
        step("mb3", MDS);
        step("mb4", MDS);
        step("mb5_done", DONE);
        @(negedge clk);
        ex_muldiv = 0;
        #1 chk("mb_run", 32'(o1), 32'(NORM));
        chk("mb_sc", 32'(sc), 9);

        mem_busy = 1; ex_branch_taken = 1;
        #1 chk("br_held", 32'(o1), 32'(FRZ));
        @(negedge clk);
        mem_busy = 0;
        #1 chk("br_release", 32'(o1), 32'(RDR));
        @(negedge clk);
        ex_muldiv = 1;
        #1 chk("md_over_br", 32'(o1), 32'(MDS));
        ex_branch_taken = 0;
        step("mdb1", MDS);
        step("mdb2", MDS);
        @(negedge clk);
        lu5(); ex_branch_taken = 1;
        #1 chk("done_redir", 32'(o1), 32'(RDD));
        @(negedge clk);
        clr();
        #1 chk("done_redir_after", 32'(o1), 32'(NORM));

        ex_muldiv = 1;
        @(negedge clk);
        @(negedge clk);
        reset = 1;
        #1 chk("rmid_out", 32'(o1), 32'(FRZ));
        chk("rmid_sc", 32'(sc), 0);
        @(negedge clk);
        reset = 0; ex_muldiv = 0;
        #1 chk("rmid_release", 32'(o1), 32'(NORM));
        @(negedge clk);
        #1 chk("rmid_sc_after", 32'(sc), 0);

        m2 = 1;
        #1 chk("lat2_stall", 32'(o2), 32'(MDS));
        step("lat2_other", NORM);
        chk("lat2_done", 32'(o2), 32'(DONE));
        @(negedge clk);
        m2 = 0;
        #1 chk("lat2_run", 32'(o2), 32'(NORM));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
